// File: rtl/muldiv_if.sv
// Request/result bundle between decode/EX and the multi-cycle multiply/divide engine.
// Handshake: start is sampled only while the engine is idle; it is answered exactly once by a one-cycle done pulse.
interface muldiv_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_div;
    logic             op_signed;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             done;
    logic             busy;
    logic             stall;
    logic             div_zero;

    modport master (
        output start, op_div, op_signed, src_a, src_b,
        input  result_lo, result_hi, done, busy, stall, div_zero
    );

    modport slave (
        input  start, op_div, op_signed, src_a, src_b,
        output result_lo, result_hi, done, busy, stall, div_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide on operand magnitudes, with a sign fixup pass.
// Produces a hi/lo pair for dual-register writeback and stalls the pipeline while running.
module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    muldiv_if.slave    bus,
    output logic [1:0] o_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIXUP = 2'd2, S_DONE = 2'd3} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_op_div;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_div_zero_start;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_sub;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept         = (r_state == S_IDLE) && bus.start;
    assign w_div_zero_start = bus.op_div && (bus.src_b == '0);
    assign w_mag_a   = (bus.op_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    assign w_mag_b   = (bus.op_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    assign w_mul_sum = {1'b0, r_acc_hi} + {1'b0, r_mag_b};
    // Divide keeps the remainder in acc_hi and the dividend/quotient in acc_lo.
    assign w_rem_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_mag_b};
    assign w_prod    = {r_acc_hi, r_acc_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = w_div_zero_start ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.done  = (r_state == S_DONE);
        bus.busy  = (r_state != S_IDLE);
        bus.stall = w_accept || (r_state == S_CALC) || (r_state == S_FIXUP);
        o_state   = r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_op_div   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_mag_b    <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_res_lo   <= '0;
            r_res_hi   <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_cnt      <= '0;
                    r_op_div   <= bus.op_div;
                    r_sign_a   <= bus.op_signed && bus.src_a[WIDTH-1];
                    r_sign_b   <= bus.op_signed && bus.src_b[WIDTH-1];
                    r_mag_b    <= w_mag_b;
                    r_acc_hi   <= '0;
                    r_acc_lo   <= w_mag_a;
                    r_div_zero <= w_div_zero_start;
                    if (w_div_zero_start) begin
                        r_res_lo <= '1;
                        r_res_hi <= bus.src_a;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_op_div) begin
                        if (w_rem_sh >= {1'b0, r_mag_b}) begin
                            r_acc_hi <= w_rem_sub[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc_hi <= w_rem_sh[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else if (r_acc_lo[0]) begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end else begin
                        r_acc_hi <= {1'b0, r_acc_hi[WIDTH-1:1]};
                        r_acc_lo <= {r_acc_hi[0], r_acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIXUP: begin
                    if (r_op_div) begin
                        r_res_lo <= (r_sign_a ^ r_sign_b) ? -r_acc_lo : r_acc_lo;
                        r_res_hi <= r_sign_a ? -r_acc_hi : r_acc_hi;
                    end else begin
                        {r_res_hi, r_res_lo} <= (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_lo = r_res_lo;
    assign bus.result_hi = r_res_hi;
    assign bus.div_zero  = r_div_zero;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases plus random operations against an integer-arithmetic model.
module tb_muldiv_sequencer;
    localparam int W = 16;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         n_checks;
    int         n_fail;
    logic [2*W:0] exp_q[$];
    logic [2*W:0] last_exp;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .o_state (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {div_zero, hi, lo} from plain signed/unsigned arithmetic.
    function automatic logic [2*W:0] model(input logic dv, input logic sg,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p, q, r;
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        if (!dv) begin
            p = sa * sb;
            return {1'b0, p[2*W-1:0]};
        end
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    task automatic run_op(input logic dv, input logic sg, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int glitch_c, input int rst_c,
                          input logic start_in_done);
        int lat;
        logic [2*W:0] exp;
        exp_q.push_back(model(dv, sg, a, b));
        lat = (dv && b == '0) ? 1 : W + 2;
        @(negedge clk);
        bus.start = 1'b1; bus.op_div = dv; bus.op_signed = sg; bus.src_a = a; bus.src_b = b;
        #1 check("stall_c0", bus.stall, 1);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.op_div = 1'($urandom_range(0, 1));
            bus.op_signed = 1'($urandom_range(0, 1));
            bus.src_a = W'($urandom);
            bus.src_b = W'($urandom);
            if (c == glitch_c) bus.start = 1'b1;
            if (c == lat && start_in_done) bus.start = 1'b1;
            if (c == rst_c) begin
                rst = 1'b1;
                #1;
                check("rst_busy", bus.busy, 0);
                check("rst_stall", bus.stall, 0);
                check("rst_done", bus.done, 0);
                check("rst_lo", bus.result_lo, 0);
                check("rst_hi", bus.result_hi, 0);
                check("rst_dz", bus.div_zero, 0);
                void'(exp_q.pop_front());
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < W + 4; k++) begin
                    @(negedge clk);
                    #1 check("rst_no_done", bus.done, 0);
                end
                return;
            end
            #1;
            check("done", bus.done, (c == lat));
            check("stall", bus.stall, (c < lat));
            check("busy", bus.busy, 1);
            if (c == lat) begin
                exp = exp_q.pop_front();
                last_exp = exp;
                check("result_lo", bus.result_lo, exp[W-1:0]);
                check("result_hi", bus.result_hi, exp[2*W-1:W]);
                check("div_zero", bus.div_zero, exp[2*W]);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("idle_busy", bus.busy, 0);
        check("idle_state", state_dbg, 0);
        check("hold_lo", bus.result_lo, last_exp[W-1:0]);
        check("hold_hi", bus.result_hi, last_exp[2*W-1:W]);
        check("hold_dz", bus.div_zero, last_exp[2*W]);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic rdv, rsg;
        n_checks = 0;
        n_fail = 0;
        last_exp = '0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op_div = 1'b0; bus.op_signed = 1'b0;
        bus.src_a = '0; bus.src_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", state_dbg, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_stall", bus.stall, 0);
        check("reset_done", bus.done, 0);
        check("reset_lo", bus.result_lo, 0);
        check("reset_hi", bus.result_hi, 0);
        check("reset_dz", bus.div_zero, 0);

        run_op(0, 0, 16'h1234, 16'h0100, -1, -1, 0);
        run_op(0, 1, 16'hFFFD, 16'h0005, -1, -1, 0);
        run_op(0, 0, 16'hFFFF, 16'hFFFF, -1, -1, 0);
        run_op(1, 1, 16'hFFF9, 16'h0002, -1, -1, 0);
        run_op(1, 0, 16'd100, 16'd7, -1, -1, 0);
        run_op(1, 0, 16'h0042, 16'h0000, -1, -1, 0);
        run_op(1, 0, 16'd100, 16'd7, -1, -1, 1);
        run_op(1, 1, 16'h8000, 16'hFFFF, -1, -1, 0);
        run_op(1, 1, 16'h8000, 16'h0000, -1, -1, 1);
        run_op(0, 1, 16'h8000, 16'h8000, -1, -1, 0);
        run_op(0, 0, 16'h1234, 16'h0100, 5, -1, 0);
        run_op(0, 0, 16'h1234, 16'h0100, -1, 9, 0);
        run_op(0, 0, 16'h1234, 16'h0100, -1, -1, 0);

        for (int i = 0; i < 40; i++) begin
            rdv = 1'($urandom_range(0, 1));
            rsg = 1'($urandom_range(0, 1));
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                ra = 16'h8000;
                rb = 16'hFFFF;
            end
            run_op(rdv, rsg, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1,
                   -1, 1'($urandom_range(0, 1)));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
